mul_sched: RTL
==============

Name: mul_sched

Overview:
- Multiply controller that shares one booth multiplier core between two requesters (issue slots 0 and 1).
- Arbitrates requests round-robin and sequences the core's start/finish handshake.
- Applies sign correction for the RISC-V M-extension variants MUL, MULH, MULHSU and MULHU.
- Returns a 32-bit result with a requester id over a valid/ready response channel.

Parameters:
- DRAIN_CYC, 36: cycles held in DRAIN after reset so that any in-flight core operation completes.
- ZERO_FAST, 1: when 1, an operand equal to zero bypasses the core.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester grant; one-hot or zero
- req_op0, req_op1  in  2 each  op code: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- req_a0, req_a1  in  32 each  rs1 operand
- req_b0, req_b1  in  32 each  rs2 operand
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester index of the result
- rsp_result  out  32  result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-low) forces:
  - state DRAIN, drain counter 0, round-robin pointer 0;
  - req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, busy 1.
  - Reset mid-operation discards the operation; no response is produced.
- DRAIN:
  - Counts DRAIN_CYC cycles, then goes to IDLE.
  - Core o_finish is ignored throughout. This covers the core not being cleared by reset.
- IDLE:
  - req_ready is combinational and asserted only in IDLE.
  - The grant goes to the requester indicated by the pointer if its valid is high, otherwise to the other one.
  - A handshake (valid & ready) latches op, a, b and id, and sets the pointer to the loser.
  - With both requesters valid continuously, grants alternate 0,1,0,1.
  - If ZERO_FAST and (a==0 or b==0), next state is DONE with result 0. Otherwise next state is ISSUE.
- ISSUE:
  - Drives core i_en=1 for exactly one cycle with A=a, B=b; next state WAIT.
- WAIT:
  - Holds i_en=0.
  - On the first cycle o_finish=1, captures core Y[63:0] as P and goes to FIX.
- FIX:
  - The core computes the signed x signed product.
  - Result select:
    - MUL: P[31:0].
    - MULH: P[63:32].
    - MULHSU: P[63:32] + (b[31] ? a : 0).
    - MULHU: P[63:32] + (a[31] ? b : 0) + (b[31] ? a : 0).
  - All additions are mod 2^32. Next state DONE.
- DONE:
  - rsp_valid=1; rsp_result and rsp_id are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, goes to IDLE. A new request can be granted in the cycle after the handshake.
- Latency, counted from the accepting edge to rsp_valid rising, with rsp_ready held high:
  - core path: 35 cycles (1 ISSUE, 1 core load, 32 shift, 1 finish-observe);
  - zero fast path: 1 cycle.
- Boundaries:
  - Requests arriving outside IDLE wait with req_ready=0. The block has no internal queue.
  - A requester dropping valid before grant is legal.
  - o_finish seen outside WAIT is ignored.

Decomposition:
- Shared package/defines: op encodings (MUL_OP_MUL/MULH/MULHSU/MULHU), state encodings, DRAIN_CYC default.
- One sub-module: the existing BOOTH_MUL core, instantiated once. The controller owns all sequencing and sign fix-up; the core is unmodified.

Test Plan:
- Reset, then requester 0 issues MUL a=7, b=-3: after 36 cycles of DRAIN, result 0xFFFFFFEB, rsp_id=0, rsp_valid exactly 35 cycles after the accepting edge.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU a=-1, b=0xFFFFFFFF → 0xFFFFFFFF.
- Both requesters valid continuously with 4 ops each: grants alternate 0,1,0,1…; every rsp_id and result matches its request.
- ZERO_FAST: MUL a=0, b=0x12345678 → result 0, rsp_valid 1 cycle after accept, core i_en never asserted.
- rsp_ready held low for 10 cycles in DONE: result and id are stable, req_ready stays 0; after release, the next grant occurs the following cycle.
- Reset asserted mid-WAIT, then released: no stale response; the following MUL a=3, b=5 returns 15 with correct latency.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared definitions for the two-slot multiply scheduler: op codes, FSM states
// and the high-word sign fix-up applied to the core's signed product.
package mul_sched_pkg;

    localparam int DRAIN_CYC_DEF = 36;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [2:0] {
        ST_DRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIX   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // The core treats both operands as signed; an operand read as unsigned with
    // bit 31 set is short by 2^32, so the other operand is added to the high word.
    function automatic logic [31:0] mul_fix(
        input logic [1:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [63:0] p
    );
        logic [31:0] hi;
        logic [31:0] corr_b_uns;
        logic [31:0] corr_a_uns;
        hi         = p[63:32];
        corr_b_uns = b[31] ? a : 32'd0;
        corr_a_uns = a[31] ? b : 32'd0;
        unique case (op)
            MUL_OP_MUL:    mul_fix = p[31:0];
            MUL_OP_MULH:   mul_fix = hi;
            MUL_OP_MULHSU: mul_fix = hi + corr_b_uns;
            default:       mul_fix = hi + corr_a_uns + corr_b_uns;
        endcase
    endfunction

endpackage

// File: rtl/mul_sched_booth.sv
// Radix-2 Booth signed 32x32 multiplier: loads on i_en, then 32 shift steps;
// o_finish rises after the last step and holds until the next load.
module mul_sched_booth (
    input  logic        i_clk,
    input  logic        i_en,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_finish,
    output logic [63:0] o_y
);

    logic [32:0] acc;
    logic [31:0] q;
    logic        q_m1;
    logic [31:0] m;
    logic [4:0]  cnt;
    logic        run;
    logic [32:0] sum;

    always_comb begin
        sum = acc;
        unique case ({q[0], q_m1})
            2'b01:   sum = acc + {m[31], m};
            2'b10:   sum = acc - {m[31], m};
            default: sum = acc;
        endcase
    end

    // No reset: this core is not cleared by the system reset, the controller drains it.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            acc      <= '0;
            q        <= i_b;
            q_m1     <= 1'b0;
            m        <= i_a;
            cnt      <= '0;
            run      <= 1'b1;
            o_finish <= 1'b0;
        end else if (run) begin
            acc  <= {sum[32], sum[32:1]};
            q    <= {sum[0], q[31:1]};
            q_m1 <= q[0];
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                run      <= 1'b0;
                o_finish <= 1'b1;
            end
        end
    end

    assign o_y = {acc[31:0], q};

endmodule

// File: rtl/mul_sched.sv
// Multiply scheduler: round-robin arbitration of two issue slots onto one Booth
// core, RISC-V M high-word sign fix-up, and a valid/ready response channel.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int ZERO_FAST = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_op0,
    input  logic [1:0]  req_op1,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_b1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        busy
);

    // Handshakes: a transfer happens on a rising clock edge where valid and ready
    // are both high; valid must not wait on ready, and rsp data holds until taken.

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  drain_cnt;
    logic        rr_ptr;

    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        id_q;
    logic [63:0] p_q;
    logic [31:0] res_q;

    logic [1:0]  grant;
    logic        gnt_id;
    logic        hs;
    logic [1:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        zero_hit;

    logic        core_en;
    logic        core_fin;
    logic [63:0] core_y;

    // Pointer slot wins when it is asking; otherwise the other slot may take it.
    always_comb begin
        grant  = 2'b00;
        gnt_id = rr_ptr;
        if (state == ST_IDLE) begin
            if (req_valid[rr_ptr]) begin
                grant[rr_ptr] = 1'b1;
                gnt_id        = rr_ptr;
            end else if (req_valid[~rr_ptr]) begin
                grant[~rr_ptr] = 1'b1;
                gnt_id         = ~rr_ptr;
            end
        end
    end

    assign hs       = |grant;
    assign sel_op   = gnt_id ? req_op1 : req_op0;
    assign sel_a    = gnt_id ? req_a1  : req_a0;
    assign sel_b    = gnt_id ? req_b1  : req_b0;
    assign zero_hit = (ZERO_FAST != 0) && ((sel_a == 32'd0) || (sel_b == 32'd0));

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = ST_IDLE;
            ST_IDLE:  if (hs) state_nxt = zero_hit ? ST_DONE : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (core_fin) state_nxt = ST_FIX;
            ST_FIX:   state_nxt = ST_DONE;
            ST_DONE:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_DRAIN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_DRAIN;
        end else begin
            state <= state_nxt;
        end
    end

    // The core keeps running through reset, so its finish flag is untrusted here.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            drain_cnt <= '0;
        end else if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rr_ptr <= 1'b0;
            op_q   <= MUL_OP_MUL;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= 1'b0;
            p_q    <= '0;
            res_q  <= '0;
        end else begin
            if (hs) begin
                rr_ptr <= ~gnt_id;
                op_q   <= sel_op;
                a_q    <= sel_a;
                b_q    <= sel_b;
                id_q   <= gnt_id;
                if (zero_hit) res_q <= '0;
            end
            if (state == ST_WAIT && core_fin) p_q <= core_y;
            if (state == ST_FIX) res_q <= mul_fix(op_q, a_q, b_q, p_q);
        end
    end

    assign core_en    = (state == ST_ISSUE);
    assign req_ready  = grant;
    assign rsp_valid  = (state == ST_DONE);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign busy       = (state != ST_IDLE);

    mul_sched_booth u_core (
        .i_clk    (i_clk),
        .i_en     (core_en),
        .i_a      (a_q),
        .i_b      (b_q),
        .o_finish (core_fin),
        .o_y      (core_y)
    );

endmodule
